// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - control, imem and IF/ID bundle between the fetch stage and its neighbours
interface fetch_stage_if #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 16
);
  logic                   halt;
  logic                   if_flush;
  logic                   pc_op;
  logic                   b_jmp;
  logic                   stall;
  logic [PC_WIDTH-1:0]    branch_offset;
  logic [PC_WIDTH-1:0]    jump_target;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] if_id_instr;
  logic [PC_WIDTH-1:0]    if_id_pc_plus2;
  logic                   if_id_valid;
  logic                   halted;

  modport master (
    output halt, if_flush, pc_op, b_jmp, stall, branch_offset, jump_target, imem_rdata,
    input  imem_addr, pc, if_id_instr, if_id_pc_plus2, if_id_valid, halted
  );

  modport slave (
    input  halt, if_flush, pc_op, b_jmp, stall, branch_offset, jump_target, imem_rdata,
    output imem_addr, pc, if_id_instr, if_id_pc_plus2, if_id_valid, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, redirect mux and IF/ID pipeline register with sticky halt
module fetch_stage #(
  parameter int                  PC_WIDTH     = 16,
  parameter int                  INSTR_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter logic [INSTR_WIDTH-1:0] BUBBLE_INSTR = 16'h8000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  bus
);
  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  state_t                 r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [PC_WIDTH-1:0]    r_pc_plus2;
  logic                   r_valid;
  logic                   r_halted;

  logic [PC_WIDTH-1:0]    w_pc_next_seq;
  logic [PC_WIDTH-1:0]    w_target_raw;
  logic [PC_WIDTH-1:0]    w_target;

  assign w_pc_next_seq = r_pc + PC_WIDTH'(2);
  assign w_target_raw  = bus.b_jmp ? (r_pc_plus2 + bus.branch_offset) : bus.jump_target;
  assign w_target      = {w_target_raw[PC_WIDTH-1:1], 1'b0};

  // A bubble replaces only the instruction and its valid flag; pc_plus2 keeps its last value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_instr    <= BUBBLE_INSTR;
      r_pc_plus2 <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.halt) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
            r_instr  <= BUBBLE_INSTR;
            r_valid  <= 1'b0;
          end else if (bus.pc_op) begin
            r_pc    <= w_target;
            r_instr <= BUBBLE_INSTR;
            r_valid <= 1'b0;
          end else if (bus.stall) begin
            if (bus.if_flush) begin
              r_instr <= BUBBLE_INSTR;
              r_valid <= 1'b0;
            end
          end else if (bus.if_flush) begin
            r_pc    <= w_pc_next_seq;
            r_instr <= BUBBLE_INSTR;
            r_valid <= 1'b0;
          end else begin
            r_pc       <= w_pc_next_seq;
            r_instr    <= bus.imem_rdata;
            r_pc_plus2 <= w_pc_next_seq;
            r_valid    <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_HALTED;
          r_halted <= 1'b1;
          r_instr  <= BUBBLE_INSTR;
          r_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr      = r_pc;
  assign bus.pc             = r_pc;
  assign bus.if_id_instr    = r_instr;
  assign bus.if_id_pc_plus2 = r_pc_plus2;
  assign bus.if_id_valid    = r_valid;
  assign bus.halted         = r_halted;
endmodule
